// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline register.
package pipe_pkg;

  // Occupancy of the two-entry buffer: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, zero on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with a skid entry so in_ready is a pure flop decode,
// breaking the combinational out_ready -> in_ready path. Includes a
// saturating count of downstream back-pressure cycles.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t state;
  beat_t  main_q, skid_q, in_beat;
  logic   in_fire, out_fire;

  assign in_beat   = {in_ctrl, in_data};
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Bubbles carry no control: main may hold a stale beat after draining.
  assign out_data = out_valid ? main_q.data : '0;
  assign out_ctrl = out_valid ? main_q.ctrl : '0;

  // Occupancy FSM and the two storage entries; flush overrides any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_beat;
            state  <= BUSY;
          end
        end
        BUSY: begin
          case ({in_fire, out_fire})
            2'b11:   main_q <= in_beat;
            2'b10: begin
              skid_q <= in_beat;
              state  <= FULL;
            end
            2'b01:   state <= EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a long random run, all
// compared against a two-deep FIFO model with a saturating stall counter.
module tb_pipe_skid_reg;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int NMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready, cnt_clr;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] stall_cnt;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [DW+CW-1:0] q[$];
  int m_cnt = 0;
  int delivered = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW+CW-1:0] m_head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic check_all(input string tag);
    logic [DW+CW-1:0] h;
    h = m_head();
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".out_data"},  64'(out_data),  64'(h[DW-1:0]));
    chk({tag, ".out_ctrl"},  64'(out_ctrl),  64'(h[DW+CW-1:DW]));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  // Advance one clock: update the FIFO model from the current inputs, then
  // compare every output just after the edge.
  task automatic cycle(input string tag);
    bit inf, outf;
    inf  = in_valid && (q.size() < 2);
    outf = out_ready && (q.size() > 0);
    if (cnt_clr) m_cnt = 0;
    else if (q.size() > 0 && !out_ready && m_cnt < NMAX) m_cnt++;
    if (outf) delivered++;
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v; in_data = d; in_ctrl = c;
  endtask

  initial begin
    int n;
    int start;
    logic [DW-1:0] ra;
    rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #3;
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data",  64'(out_data),  64'd0);
    chk("rst.stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back streaming, one cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 8'h01); cycle("s11"); chk("s11.data", 64'(out_data), 64'h11);
    drive(1'b1, 32'h22, 8'h02); cycle("s22"); chk("s22.data", 64'(out_data), 64'h22);
    chk("s22.rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h33, 8'h03); cycle("s33"); chk("s33.data", 64'(out_data), 64'h33);
    drive(1'b0, '0, '0); cycle("sdrain");
    chk("sdrain.valid", 64'(out_valid), 64'd0);
    chk("s.stall", 64'(stall_cnt), 64'd0);

    // Back-pressure fills the skid; release drains in order.
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 8'h11); cycle("a1");
    drive(1'b1, 32'hA2, 8'h12); cycle("a2");
    chk("a.full_rdy", 64'(in_ready), 64'd0);
    chk("a.hold",     64'(out_data), 64'hA1);
    drive(1'b0, '0, '0); out_ready = 1'b1; cycle("a_rel");
    chk("a.second", 64'(out_data), 64'hA2);
    cycle("a_drain");
    chk("a.empty", 64'(out_valid), 64'd0);

    // Flush while FULL, then flush from BUSY discarding a same-cycle accept.
    out_ready = 1'b0;
    drive(1'b1, 32'hB1, 8'h21); cycle("b1");
    drive(1'b1, 32'hB2, 8'h22); cycle("b2");
    drive(1'b1, 32'hB3, 8'h23); flush = 1'b1; cycle("bflush");
    chk("b.valid", 64'(out_valid), 64'd0);
    chk("b.data",  64'(out_data),  64'd0);
    chk("b.ctrl",  64'(out_ctrl),  64'd0);
    flush = 1'b0; drive(1'b1, 32'hB4, 8'h24); cycle("b4");
    drive(1'b1, 32'hB5, 8'h25); flush = 1'b1; out_ready = 1'b1; cycle("bflush2");
    flush = 1'b0; drive(1'b0, '0, '0); cycle("bpost");
    chk("b.no_b5", 64'(out_valid), 64'd0);

    // Saturating stall counter and its clear.
    cnt_clr = 1'b1; cycle("cclr0"); cnt_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hC1, 8'h31); cycle("c1");
    drive(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) cycle("cstall");
    chk("c.sat", 64'(stall_cnt), 64'd15);
    cnt_clr = 1'b1; cycle("cclr");
    chk("c.clr", 64'(stall_cnt), 64'd0);
    cnt_clr = 1'b0;

    // Asynchronous reset while FULL.
    drive(1'b1, 32'hC2, 8'h32); cycle("c2");
    drive(1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.data",  64'(out_data),  64'd0);
    chk("ar.rdy",   64'(in_ready),  64'd1);
    chk("ar.stall", 64'(stall_cnt), 64'd0);
    q.delete(); m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hD1, 8'h41); cycle("ar_post");
    chk("ar.first", 64'(out_data), 64'hD1);

    // Random traffic against the FIFO model.
    start = delivered;
    n = 0;
    while ((delivered - start) < 10000 && n < 60000) begin
      ra = $urandom;
      drive($urandom_range(0, 9) < 7, ra, 8'($urandom));
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 299) == 0;
      cnt_clr   = $urandom_range(0, 63) == 0;
      if ((n % 16) == 0) begin
        out_ready = ~out_ready; #1;
        chk("rnd.indep", 64'(in_ready), 64'(q.size() < 2));
        out_ready = ~out_ready; #1;
      end
      cycle("rnd");
      n++;
    end
    chk("rnd.beats", 64'((delivered - start) >= 10000), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried per beat.
REQ-002 Parameter CTRL_W, default 8, width of the control bundle (regWrite/memWrite/resultSrc-style bits) per beat.
REQ-003 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 flush  in  1  synchronous kill of all held beats.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-011 out_valid  out  1  beat presented downstream.
REQ-012 out_ready  in  1  downstream accepts the beat.
REQ-013 out_data  out  DATA_W  downstream payload.
REQ-014 out_ctrl  out  CTRL_W  downstream control bundle.
REQ-015 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-016 stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Function
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-018 Two storage entries, main and skid; state machine EMPTY (0 held), BUSY (main held), FULL (main+skid held).
REQ-019 in_ready = (state != FULL), decoded from registered state only; no combinational path out_ready -> in_ready.
REQ-020 out_valid = (state != EMPTY); out_data/out_ctrl driven from main.
REQ-021 out_data and out_ctrl SHALL be all-zero whenever out_valid=0 (bubble carries no control).
REQ-022 EMPTY: in_fire -> main<=in, BUSY; else stay.
REQ-023 BUSY: in_fire & out_fire -> main<=in, stay BUSY; in_fire & !out_fire -> skid<=in, FULL; !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-024 FULL: out_fire -> main<=skid, BUSY; else hold both entries (stall).
REQ-025 Latency: beat accepted at edge N appears on out_* in cycle N+1; throughput one beat/cycle with out_ready=1.
REQ-026 Order preserved; no beat duplicated or dropped except by flush.
REQ-027 flush=1 has priority over all transfers: next state EMPTY, main and skid zeroed, any in_fire in that cycle discarded; an out_fire in the flush cycle counts as delivered.
REQ-028 stall_cnt increments by 1 in each cycle with out_valid=1 & out_ready=0; holds at 2^CNT_W-1.
REQ-029 cnt_clr=1 zeroes stall_cnt next edge, overriding increment; flush does not affect stall_cnt.

Reset
REQ-030 rst_n=0 asynchronously forces state=EMPTY, main=0, skid=0, stall_cnt=0; outputs: out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_cnt=0.
REQ-031 Reset asserted mid-transfer SHALL discard all held beats; first cycle after release behaves as EMPTY.

Structure
REQ-032 Package pipe_pkg SHALL hold the state enum typedef (EMPTY/BUSY/FULL) and default width constants.
REQ-033 Saturating counter SHALL be a sub-module sat_counter (parameter W; inputs inc, clr).
REQ-034 All sequential logic in flops with asynchronous active-low reset; no latches.

Verification
REQ-035 Stream 0x11,0x22,0x33 with out_ready=1 -> outputs appear one cycle later, back-to-back, in_ready stays 1, stall_cnt=0.
REQ-036 Accept 0xA1, drop out_ready, send 0xA2 -> state FULL, in_ready=0, out_data=0xA1 held; raise out_ready -> 0xA1 then 0xA2, no loss.
REQ-037 FULL with 0xB1/0xB2, pulse flush with in_valid=1 (0xB3) -> next cycle out_valid=0, out_data=0, out_ctrl=0, 0xB3 never emitted.
REQ-038 CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15; cnt_clr pulse -> 0.
REQ-039 Assert rst_n=0 between edges while FULL -> out_valid, out_data drop to 0 immediately, in_ready=1.
REQ-040 Random in_valid/out_ready (10k beats) vs. scoreboard queue -> order and count match, in_ready never depends on same-cycle out_ready.
